intr_cntrl_param: RTL and testbench

//  Parametrised next-generation interrupt controller: N_SRC request lines, per-source mask and

---
 rtl/intr_cntrl_param_pkg.sv | 35 +++
 rtl/intr_prio_arb.sv | 60 ++++++
 rtl/intr_cntrl_param.sv | 187 ++++++++++++++++++
 tb/tb_intr_cntrl_param.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_cntrl_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intr_cntrl_param_pkg
//  Description : Shared op codes, arbitration modes and FSM states for the
//                parametrised interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package intr_cntrl_param_pkg;

    localparam logic [1:0] c_OP_MODE = 2'b00;
    localparam logic [1:0] c_OP_RANK = 2'b01;
    localparam logic [1:0] c_OP_MASK = 2'b10;
    localparam logic [1:0] c_OP_TRIG = 2'b11;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_PRIO   = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_RSVD   = 2'd3
    } arb_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAISE   = 2'd1,
        ST_VECTOR  = 2'd2,
        ST_SERVICE = 2'd3
    } state_e;

    // Source index successor, wrapping at the number of sources.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : intr_cntrl_param_pkg
`default_nettype wire

// File: rtl/intr_prio_arb.sv
`default_nettype none
// ============================================================================
//  Module      : intr_prio_arb
//  Description : Combinational winner selection over pending sources in
//                fixed-ID, programmable-rank or rotating mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module intr_prio_arb
    import intr_cntrl_param_pkg::*;
#(
    parameter int N_SRC = 16,
    parameter int ID_W  = $clog2(N_SRC)
)(
    input  logic [N_SRC-1:0]           i_pend,
    input  logic [N_SRC-1:0][ID_W-1:0] i_rank,
    input  arb_mode_e                  i_mode,
    input  logic [ID_W-1:0]            i_rr_ptr,
    output logic                       o_valid,
    output logic [ID_W-1:0]            o_id
);

    logic [ID_W-1:0] w_fix_id;
    logic [ID_W-1:0] w_prio_id;
    logic [ID_W-1:0] w_prio_rank;
    logic [ID_W-1:0] w_rot_id;
    logic            w_rot_vld;

    // Scanning downwards lets the lowest qualifying index win without a break.
    always_comb begin
        w_fix_id    = '0;
        w_prio_id   = '0;
        w_prio_rank = '1;
        w_rot_id    = '0;
        w_rot_vld   = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_pend[i]) begin
                w_fix_id = ID_W'(i);
                if (i_rank[i] <= w_prio_rank) begin
                    w_prio_id   = ID_W'(i);
                    w_prio_rank = i_rank[i];
                end
                if (ID_W'(i) >= i_rr_ptr) begin
                    w_rot_id  = ID_W'(i);
                    w_rot_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_valid = |i_pend;
        case (i_mode)
            MODE_PRIO:   o_id = w_prio_id;
            MODE_ROTATE: o_id = w_rot_vld ? w_rot_id : w_fix_id;
            default:     o_id = w_fix_id;
        endcase
    end

endmodule : intr_prio_arb
`default_nettype wire

// File: rtl/intr_cntrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : intr_cntrl_param
//  Description : Parametrised interrupt controller with mask/trigger config,
//                three arbitration modes and a raise/vector/EOI handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module intr_cntrl_param
    import intr_cntrl_param_pkg::*;
#(
    parameter int               N_SRC    = 16,
    parameter int               ID_W     = $clog2(N_SRC),
    parameter int               BUS_W    = 16,
    parameter logic [BUS_W-1:0] VEC_BASE = 16'h5800,
    parameter logic [BUS_W-1:0] EOI_BASE = 16'hA000
)(
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [N_SRC-1:0] intr_rq,
    input  logic             cmd_we,
    input  logic [BUS_W-1:0] cmd_data,
    input  logic [BUS_W-1:0] intr_bus_in,
    input  logic             intr_ack_n,
    output logic             intr_out,
    output logic             bus_oe,
    output logic [BUS_W-1:0] intr_bus_out,
    output logic [ID_W-1:0]  cur_id,
    output logic             busy,
    output logic             err_pulse
);

    arb_mode_e                  r_mode;
    logic [N_SRC-1:0][ID_W-1:0] r_rank;
    logic [N_SRC-1:0]           r_mask;
    logic [N_SRC-1:0]           r_trig;
    logic [N_SRC-1:0]           r_rq;
    logic [N_SRC-1:0]           r_edge;
    logic                       r_ack_n_q;
    logic [ID_W-1:0]            r_rr_ptr;
    state_e                     r_state;
    logic [ID_W-1:0]            r_cur_id;
    logic                       r_intr_out;
    logic                       r_bus_oe;
    logic [BUS_W-1:0]           r_bus_out;
    logic                       r_err;

    state_e                     w_state_nxt;
    logic [N_SRC-1:0]           w_pend;
    logic [N_SRC-1:0]           w_edge_set;
    logic [N_SRC-1:0]           w_edge_clr_vec;
    logic                       w_edge_clr;
    logic                       w_ack;
    logic                       w_cmd_ok;
    logic                       w_eoi_ok;
    logic                       w_err;
    logic                       w_arb_vld;
    logic [ID_W-1:0]            w_arb_id;
    logic [1:0]                 w_op;
    logic [ID_W-1:0]            w_cmd_id;
    logic [BUS_W-1:0]           w_vec_word;
    logic [BUS_W-1:0]           w_eoi_word;

    assign w_op       = cmd_data[BUS_W-1:BUS_W-2];
    assign w_cmd_id   = cmd_data[ID_W-1:0];
    assign w_ack      = r_ack_n_q & ~intr_ack_n;
    assign w_vec_word = VEC_BASE | BUS_W'(r_cur_id);
    assign w_eoi_word = EOI_BASE | BUS_W'(r_cur_id);

    // Masked edges are never latched, so unmasking later cannot replay them.
    assign w_edge_set     = intr_rq & ~r_rq & r_trig & ~r_mask;
    assign w_edge_clr_vec = w_edge_clr ? ({{(N_SRC-1){1'b0}}, 1'b1} << r_cur_id) : '0;
    assign w_pend         = ((~r_trig & r_rq) | (r_trig & r_edge)) & ~r_mask;

    generate
        if (BUS_W - 2 > 2 * ID_W) begin : g_unused_payload
            logic w_unused_payload;
            assign w_unused_payload = ^cmd_data[BUS_W-3:2*ID_W];
        end
    endgenerate

    intr_prio_arb #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_arb (
        .i_pend   (w_pend),
        .i_rank   (r_rank),
        .i_mode   (r_mode),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_arb_vld),
        .o_id     (w_arb_id)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ok    = 1'b0;
        w_eoi_ok    = 1'b0;
        w_edge_clr  = 1'b0;
        w_err       = 1'b0;
        if (cmd_we) begin
            if (r_state == ST_IDLE) w_cmd_ok = 1'b1;
            else                    w_err    = 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_arb_vld) w_state_nxt = ST_RAISE;
            end
            ST_RAISE: begin
                // An ack arriving with the drop still gets its vector.
                if (w_ack) begin
                    w_state_nxt = ST_VECTOR;
                    w_edge_clr  = 1'b1;
                end else if (!r_trig[r_cur_id] && !r_rq[r_cur_id]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_VECTOR: begin
                if (w_ack) w_state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (w_ack) begin
                    if (intr_bus_in == w_eoi_word) begin
                        w_state_nxt = ST_IDLE;
                        w_eoi_ok    = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_mode    <= MODE_FIXED;
            for (int i = 0; i < N_SRC; i++) r_rank[i] <= ID_W'(i);
            r_mask    <= '0;
            r_trig    <= '0;
            r_rq      <= '0;
            r_edge    <= '0;
            r_ack_n_q <= 1'b1;
            r_rr_ptr  <= '0;
        end else begin
            r_rq      <= intr_rq;
            r_ack_n_q <= intr_ack_n;
            r_edge    <= ((r_edge & ~w_edge_clr_vec) | w_edge_set) & r_trig;
            if (w_eoi_ok) r_rr_ptr <= ID_W'(wrap_inc(int'(r_cur_id), N_SRC));
            if (w_cmd_ok) begin
                case (w_op)
                    c_OP_MODE: r_mode           <= arb_mode_e'(cmd_data[1:0]);
                    c_OP_RANK: r_rank[w_cmd_id] <= cmd_data[2*ID_W-1:ID_W];
                    c_OP_MASK: r_mask[w_cmd_id] <= cmd_data[ID_W];
                    c_OP_TRIG: r_trig[w_cmd_id] <= cmd_data[ID_W];
                    default:   ;
                endcase
            end
        end
    end

    // Handshake outputs follow the state register by one cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_cur_id   <= '0;
            r_intr_out <= 1'b0;
            r_bus_oe   <= 1'b0;
            r_bus_out  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            if (r_state == ST_IDLE && w_arb_vld) r_cur_id <= w_arb_id;
            r_intr_out <= (r_state == ST_RAISE) || (r_state == ST_VECTOR);
            r_bus_oe   <= (r_state == ST_VECTOR);
            r_bus_out  <= (r_state == ST_VECTOR) ? w_vec_word : '0;
            r_err      <= w_err;
        end
    end

    assign intr_out     = r_intr_out;
    assign bus_oe       = r_bus_oe;
    assign intr_bus_out = r_bus_out;
    assign cur_id       = r_cur_id;
    assign busy         = (r_state != ST_IDLE);
    assign err_pulse    = r_err;

endmodule : intr_cntrl_param
`default_nettype wire

// File: tb/tb_intr_cntrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intr_cntrl_param
//  Description : Directed table-driven bench for the interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_intr_cntrl_param;

    logic        clk_in     = 1'b0;
    logic        rst_n_in   = 1'b0;
    logic [15:0] intr_rq    = '0;
    logic        cmd_we     = 1'b0;
    logic [15:0] cmd_data   = '0;
    logic [15:0] intr_bus_in = '0;
    logic        intr_ack_n = 1'b1;
    logic        intr_out;
    logic        bus_oe;
    logic [15:0] intr_bus_out;
    logic [3:0]  cur_id;
    logic        busy;
    logic        err_pulse;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [15:0] rq_pre;
        logic [3:0]  id;
        logic [15:0] rq_svc;
        logic [15:0] rq_eoi;
    } row_t;

    row_t tab [24];

    intr_cntrl_param #(
        .N_SRC    (16),
        .ID_W     (4),
        .BUS_W    (16),
        .VEC_BASE (16'h5800),
        .EOI_BASE (16'hA000)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .intr_rq      (intr_rq),
        .cmd_we       (cmd_we),
        .cmd_data     (cmd_data),
        .intr_bus_in  (intr_bus_in),
        .intr_ack_n   (intr_ack_n),
        .intr_out     (intr_out),
        .bus_oe       (bus_oe),
        .intr_bus_out (intr_bus_out),
        .cur_id       (cur_id),
        .busy         (busy),
        .err_pulse    (err_pulse)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mk(input logic [1:0] op, input logic [3:0] hi, input logic [3:0] lo);
        return {op, 6'b0, hi, lo};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0; intr_rq = '0; intr_ack_n = 1'b1;
        cmd_we = 1'b0; cmd_data = '0; intr_bus_in = '0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic cmd(input logic [15:0] w, input string nm);
        cmd_we = 1'b1; cmd_data = w;
        @(negedge clk_in);
        cmd_we = 1'b0; cmd_data = '0;
        chk({nm, "_noerr"}, err_pulse, 0);
    endtask

    task automatic wait_intr();
        int n = 0;
        while (!intr_out && n < 40) begin @(negedge clk_in); n++; end
    endtask

    task automatic wait_oe();
        int n = 0;
        while (!bus_oe && n < 10) begin @(negedge clk_in); n++; end
    endtask

    task automatic pulse_ack();
        intr_ack_n = 1'b0;
        @(negedge clk_in);
        intr_ack_n = 1'b1;
    endtask

    // Full handshake for one expected source, with optional fault injection.
    task automatic serve(input logic [3:0] id, input logic [15:0] rq_svc, input logic [15:0] rq_eoi,
                         input bit bad_eoi, input bit vec_cmd, input string nm);
        wait_intr();
        chk({nm, "_intr"}, intr_out, 1);
        chk({nm, "_id"}, cur_id, id);
        pulse_ack();
        wait_oe();
        chk({nm, "_oe"}, bus_oe, 1);
        chk({nm, "_vec"}, intr_bus_out, 16'h5800 | {12'h0, id});
        if (vec_cmd) begin
            cmd_we = 1'b1; cmd_data = mk(2'b10, 4'h1, id);
            @(negedge clk_in);
            cmd_we = 1'b0; cmd_data = '0;
            chk({nm, "_vcmd_err"}, err_pulse, 1);
            chk({nm, "_vcmd_oe"}, bus_oe, 1);
        end
        pulse_ack();
        intr_rq = rq_svc;
        @(negedge clk_in);
        chk({nm, "_svc_intr"}, intr_out, 0);
        chk({nm, "_svc_oe"}, bus_oe, 0);
        if (bad_eoi) begin
            intr_bus_in = 16'hA000 | {12'h0, id + 4'd1};
            pulse_ack();
            intr_bus_in = '0;
            chk({nm, "_bad_err"}, err_pulse, 1);
            chk({nm, "_bad_busy"}, busy, 1);
            @(negedge clk_in);
        end
        intr_rq     = rq_eoi;
        intr_bus_in = 16'hA000 | {12'h0, id};
        pulse_ack();
        intr_bus_in = '0;
        chk({nm, "_eoi_busy"}, busy, 0);
        chk({nm, "_eoi_err"}, err_pulse, 0);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            intr_rq = tab[k].rq_pre;
            serve(tab[k].id, tab[k].rq_svc, tab[k].rq_eoi, 1'b0, 1'b0, $sformatf("row%0d", k));
        end
    endtask

    initial begin
        // FIXED sequence, PRIO ranks, PRIO tie, then 17 rotating services.
        tab[0] = '{16'h00A4, 4'd2, 16'h00A0, 16'h00A0};
        tab[1] = '{16'h00A0, 4'd5, 16'h0080, 16'h0080};
        tab[2] = '{16'h0080, 4'd7, 16'h0000, 16'h0000};
        tab[3] = '{16'h0021, 4'd5, 16'h0001, 16'h0001};
        tab[4] = '{16'h0001, 4'd0, 16'h0000, 16'h0000};
        tab[5] = '{16'h000A, 4'd1, 16'h0008, 16'h0008};
        tab[6] = '{16'h0008, 4'd3, 16'h0000, 16'h0000};
        for (int k = 0; k < 17; k++) tab[7 + k] = '{16'hFFFF, 4'(k % 16), 16'hFFFF, 16'hFFFF};

        do_reset();
        chk("rst_intr", intr_out, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_bus", intr_bus_out, 0);
        chk("rst_id", cur_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_pulse, 0);

        pulse_ack();
        @(negedge clk_in);
        chk("idle_ack_busy", busy, 0);

        intr_rq = 16'h0004;
        @(negedge clk_in); chk("lat_e1_intr", intr_out, 0);
        @(negedge clk_in); chk("lat_e2_busy", busy, 1); chk("lat_e2_intr", intr_out, 0);
        @(negedge clk_in); chk("lat_e3_intr", intr_out, 1);
        serve(4'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, "lat");

        run_rows(0, 2);

        cmd(mk(2'b00, 4'h0, 4'h1), "t2_mode");
        cmd(mk(2'b01, 4'h0, 4'h5), "t2_rank5");
        cmd(mk(2'b01, 4'h9, 4'h0), "t2_rank0");
        run_rows(3, 4);
        cmd(mk(2'b01, 4'h2, 4'h3), "t2_rank3");
        cmd(mk(2'b01, 4'h2, 4'h1), "t2_rank1");
        run_rows(5, 6);

        intr_rq = 16'h0002;
        wait_intr();
        chk("spur_raise", intr_out, 1);
        intr_rq = '0;
        repeat (3) @(negedge clk_in);
        chk("spur_busy", busy, 0);
        chk("spur_intr", intr_out, 0);
        chk("spur_err", err_pulse, 0);

        intr_rq = 16'h0004;
        serve(4'd2, 16'h0004, 16'h0004, 1'b1, 1'b1, "t5");
        serve(4'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, "t5_cfg");

        do_reset();
        cmd(mk(2'b00, 4'h0, 4'h2), "t3_mode");
        run_rows(7, 23);

        do_reset();
        cmd(mk(2'b11, 4'h1, 4'h4), "t4_trig");
        intr_rq = 16'h0010;
        @(negedge clk_in);
        intr_rq = '0;
        serve(4'd4, 16'h0010, 16'h0000, 1'b0, 1'b0, "t4a");
        serve(4'd4, 16'h0000, 16'h0000, 1'b0, 1'b0, "t4b");
        repeat (10) @(negedge clk_in);
        chk("t4_quiet_busy", busy, 0);
        cmd(mk(2'b10, 4'h1, 4'h4), "t4_mask");
        intr_rq = 16'h0010;
        @(negedge clk_in);
        intr_rq = '0;
        repeat (10) @(negedge clk_in);
        chk("t4_mask_intr", intr_out, 0);
        chk("t4_mask_busy", busy, 0);

        cmd(mk(2'b10, 4'h1, 4'h0), "t6_mask0");
        cmd(mk(2'b00, 4'h0, 4'h1), "t6_mode");
        cmd(mk(2'b01, 4'h0, 4'h1), "t6_rank1");
        intr_rq = 16'h0003;
        wait_intr();
        chk("t6_intr", intr_out, 1);
        chk("t6_id", cur_id, 1);
        pulse_ack();
        wait_oe();
        chk("t6_oe", bus_oe, 1);
        rst_n_in = 1'b0;
        #1;
        chk("t6_rst_intr", intr_out, 0);
        chk("t6_rst_oe", bus_oe, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_bus", intr_bus_out, 0);
        chk("t6_rst_id", cur_id, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        serve(4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, "t6_post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_intr_cntrl_param
`default_nettype wire
